// File: rtl/product_burst_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_burst_accumulator_if
//
// Purpose: groups the upstream memory-read handshake and the downstream
// result handshake of product_burst_accumulator into one bundle.
//
// Parameters:
//   DATA_W  width of memVal words
//   DEPTH   words per burst
//
// Signals (direction as seen by the accumulator, i.e. the slave modport):
//   start         in   request one burst drain
//   RDY_readMem   in   upstream memory full and ready to be read
//   EN_readMem    out  one-cycle read request to upstream
//   memVal        in   burst data word
//   VALID_memVal  in   memVal valid this cycle
//   sum           out  accumulated sum (ACC_W bits)
//   word_count    out  words accepted in current/last burst (CNT_W bits)
//   VALID_sum     out  result final and stable
//   ACK_sum       in   consumer accepts result
//   busy          out  accumulator not idle
//   err_timeout   out  last burst ended by watchdog
//   max_val       out  largest word seen (present only with ACC_MAX_EN)
//
// Modports: slave = the accumulator, master = the environment driving it.
// Optional feature macro: ACC_MAX_EN adds max_val.
// ---------------------------------------------------------------------------
interface product_burst_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
);
  localparam int ACC_W = DATA_W + $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              start;
  logic              RDY_readMem;
  logic              EN_readMem;
  logic [DATA_W-1:0] memVal;
  logic              VALID_memVal;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  word_count;
  logic              VALID_sum;
  logic              ACK_sum;
  logic              busy;
  logic              err_timeout;
`ifdef ACC_MAX_EN
  logic [DATA_W-1:0] max_val;

  modport slave (
    input  start, RDY_readMem, memVal, VALID_memVal, ACK_sum,
    output EN_readMem, sum, word_count, VALID_sum, busy, err_timeout, max_val
  );

  modport master (
    output start, RDY_readMem, memVal, VALID_memVal, ACK_sum,
    input  EN_readMem, sum, word_count, VALID_sum, busy, err_timeout, max_val
  );
`else
  modport slave (
    input  start, RDY_readMem, memVal, VALID_memVal, ACK_sum,
    output EN_readMem, sum, word_count, VALID_sum, busy, err_timeout
  );

  modport master (
    output start, RDY_readMem, memVal, VALID_memVal, ACK_sum,
    input  EN_readMem, sum, word_count, VALID_sum, busy, err_timeout
  );
`endif
endinterface

// File: rtl/product_burst_accumulator.sv
// ---------------------------------------------------------------------------
// product_burst_accumulator
//
// Purpose: drains one full burst from the upstream multiplier's product
// memory and sums every word (unsigned). A watchdog ends a burst that stalls
// for TIMEOUT consecutive cycles and flags it with err_timeout.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   bus        slave modport of product_burst_accumulator_if
//                   (read handshake, burst data, result handshake, status)
//   dbg_state  out  current FSM state (IDLE=0, WAIT_RDY=1, COLLECT=2, DONE=3)
//
// Parameters:
//   DATA_W   width of memVal words
//   DEPTH    words per burst
//   TIMEOUT  max consecutive idle COLLECT cycles before abort; must exceed
//            the 2-3 cycle upstream read latency
//
// Optional feature macro: ACC_MAX_EN -- when defined, bus.max_val tracks the
// largest word accepted in the current/last burst.
//
// Handshakes:
//   Read request : EN_readMem is asserted combinationally in WAIT_RDY
//                  while RDY_readMem is high; that same cycle is the only
//                  cycle of the request, so exactly one pulse per burst.
//   Burst data   : a word is consumed on every COLLECT cycle where
//                  VALID_memVal is high; there is no back-pressure.
//   Result       : VALID_sum stays high (with sum/word_count/err_timeout
//                  frozen) until a cycle with ACK_sum high; the transfer
//                  completes on that edge and the block returns to IDLE.
// ---------------------------------------------------------------------------
module product_burst_accumulator #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  product_burst_accumulator_if.slave   bus,
  output logic [1:0]                   dbg_state
);

  localparam int ACC_W  = DATA_W + $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY = 2'd1;
  localparam logic [1:0] ST_COLLECT  = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [ACC_W-1:0]  sum_q,      sum_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              err_q,      err_d;
`ifdef ACC_MAX_EN
  logic [DATA_W-1:0] max_q,      max_d;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    word_cnt_d = word_cnt_q;
    idle_cnt_d = idle_cnt_q;
    err_d      = err_q;
`ifdef ACC_MAX_EN
    max_d      = max_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_WAIT_RDY;
        end
      end

      ST_WAIT_RDY: begin
        // The read request fires this cycle; results of the previous burst
        // are kept visible until now and cleared on entry to COLLECT.
        if (bus.RDY_readMem) begin
          state_d    = ST_COLLECT;
          sum_d      = '0;
          word_cnt_d = '0;
          idle_cnt_d = '0;
          err_d      = 1'b0;
`ifdef ACC_MAX_EN
          max_d      = '0;
`endif
        end
      end

      ST_COLLECT: begin
        if (bus.VALID_memVal) begin
          sum_d      = sum_q + ACC_W'(bus.memVal);
          word_cnt_d = word_cnt_q + CNT_W'(1);
          idle_cnt_d = '0;
`ifdef ACC_MAX_EN
          if (bus.memVal > max_q) begin
            max_d = bus.memVal;
          end
`endif
          // Compare the pre-increment count so the DEPTH-th word ends the burst.
          if (word_cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = ST_DONE;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (bus.ACK_sum) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
      err_q      <= 1'b0;
`ifdef ACC_MAX_EN
      max_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      word_cnt_q <= word_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
`ifdef ACC_MAX_EN
      max_q      <= max_d;
`endif
    end
  end

  // Outputs
  assign bus.EN_readMem  = (state_q == ST_WAIT_RDY) && bus.RDY_readMem;
  assign bus.VALID_sum   = (state_q == ST_DONE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.sum         = sum_q;
  assign bus.word_count  = word_cnt_q;
  assign bus.err_timeout = err_q;
`ifdef ACC_MAX_EN
  assign bus.max_val     = max_q;
`endif
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_product_burst_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_burst_accumulator
//
// Directed bench for product_burst_accumulator: full bursts, saturating
// data, watchdog abort, DONE hold, mid-burst reset, optional max tracking
// (ACC_MAX_EN) and ignored start/ACK_sum outside their states.
// ---------------------------------------------------------------------------
module tb_product_burst_accumulator;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_RDY = 2'd1;
  localparam logic [1:0] S_COLLECT  = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int en_base;
  int cyc;

  logic [DATA_W-1:0] data_a [DEPTH];

  product_burst_accumulator_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  product_burst_accumulator #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count read-request pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.EN_readMem === 1'b1) en_cnt <= en_cnt + 1;
  end

  // Global time limit
  initial begin
    #2ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, optional RDY_readMem delay, then one-cycle upstream latency
  task automatic start_burst(input int rdy_delay);
    bus.RDY_readMem = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("enter_wait_rdy", 64'(dbg_state), 64'(S_WAIT_RDY));
    for (int i = 0; i < rdy_delay; i++) begin
      check_val("no_en_before_rdy", 64'(bus.EN_readMem), 64'd0);
      tick();
    end
    bus.RDY_readMem = 1'b1;
    tick();
    bus.RDY_readMem = 1'b0;
    check_val("enter_collect", 64'(dbg_state), 64'(S_COLLECT));
    bus.VALID_memVal = 1'b0;
    tick();
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      bus.VALID_memVal = 1'b1;
      bus.memVal = data_a[i];
      tick();
    end
    bus.VALID_memVal = 1'b0;
  endtask

  task automatic fill_const(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DEPTH; i++) data_a[i] = v;
  endtask

  task automatic ack_result();
    bus.ACK_sum = 1'b1;
    tick();
    bus.ACK_sum = 1'b0;
    check_val("ack_to_idle", 64'(dbg_state), 64'(S_IDLE));
    check_val("ack_busy_low", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.RDY_readMem  = 1'b0;
    bus.memVal       = '0;
    bus.VALID_memVal = 1'b0;
    bus.ACK_sum      = 1'b0;
    tick();
    tick();

    // Reset state
    check_val("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check_val("rst_sum", 64'(bus.sum), 64'd0);
    check_val("rst_wc", 64'(bus.word_count), 64'd0);
    check_val("rst_err", 64'(bus.err_timeout), 64'd0);
    check_val("rst_valid", 64'(bus.VALID_sum), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_en", 64'(bus.EN_readMem), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: 64 words of 1
    en_base = en_cnt;
    fill_const(32'd1);
    start_burst(0);
    send_words(DEPTH);
    check_val("t1_state", 64'(dbg_state), 64'(S_DONE));
    check_val("t1_valid", 64'(bus.VALID_sum), 64'd1);
    check_val("t1_sum", 64'(bus.sum), 64'd64);
    check_val("t1_wc", 64'(bus.word_count), 64'd64);
    check_val("t1_err", 64'(bus.err_timeout), 64'd0);
    check_val("t1_en_pulses", 64'(en_cnt - en_base), 64'd1);
`ifdef ACC_MAX_EN
    check_val("t1_max", 64'(bus.max_val), 64'd1);
`endif
    ack_result();

    // 2: 64 words of all-ones, RDY_readMem late by 3 cycles
    en_base = en_cnt;
    fill_const(32'hFFFF_FFFF);
    start_burst(3);
    send_words(DEPTH);
    check_val("t2_sum", 64'(bus.sum), 64'h3F_FFFF_FFC0);
    check_val("t2_wc", 64'(bus.word_count), 64'd64);
    check_val("t2_en_pulses", 64'(en_cnt - en_base), 64'd1);
    ack_result();

    // 3: 10 words of 5 then stall -> watchdog after 16 idle cycles
    fill_const(32'd5);
    start_burst(0);
    send_words(10);
    cyc = 0;
    while (bus.VALID_sum !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check_val("t3_idle_cycles", 64'(cyc), 64'd16);
    check_val("t3_err", 64'(bus.err_timeout), 64'd1);
    check_val("t3_wc", 64'(bus.word_count), 64'd10);
    check_val("t3_sum", 64'(bus.sum), 64'd50);

    // 4: DONE holds for 20 cycles of ignored data, then ACK
    for (int i = 0; i < 20; i++) begin
      bus.VALID_memVal = i[0];
      bus.memVal = 32'h0000_FFFF;
      tick();
    end
    bus.VALID_memVal = 1'b0;
    check_val("t4_state", 64'(dbg_state), 64'(S_DONE));
    check_val("t4_sum", 64'(bus.sum), 64'd50);
    check_val("t4_wc", 64'(bus.word_count), 64'd10);
    check_val("t4_err", 64'(bus.err_timeout), 64'd1);
    ack_result();
    check_val("t4_sum_held_idle", 64'(bus.sum), 64'd50);

    // 5: reset after 30 words, then a fresh burst of 3s
    fill_const(32'd9);
    start_burst(0);
    send_words(30);
    rst_n = 1'b0;
    tick();
    check_val("t5_state", 64'(dbg_state), 64'(S_IDLE));
    check_val("t5_sum", 64'(bus.sum), 64'd0);
    check_val("t5_wc", 64'(bus.word_count), 64'd0);
    check_val("t5_busy", 64'(bus.busy), 64'd0);
    check_val("t5_valid", 64'(bus.VALID_sum), 64'd0);
    check_val("t5_en", 64'(bus.EN_readMem), 64'd0);
`ifdef ACC_MAX_EN
    check_val("t5_max", 64'(bus.max_val), 64'd0);
`endif
    rst_n = 1'b1;
    tick();
    fill_const(32'd3);
    start_burst(0);
    send_words(DEPTH);
    check_val("t5_sum_fresh", 64'(bus.sum), 64'd192);
    check_val("t5_wc_fresh", 64'(bus.word_count), 64'd64);
    check_val("t5_err_fresh", 64'(bus.err_timeout), 64'd0);
    ack_result();

`ifdef ACC_MAX_EN
    // 6: ramp with one large word
    for (int i = 0; i < DEPTH; i++) data_a[i] = 32'(i);
    data_a[17] = 32'hDEAD_BEEF;
    start_burst(0);
    send_words(DEPTH);
    check_val("t6_max", 64'(bus.max_val), 64'hDEAD_BEEF);
    check_val("t6_sum", 64'(bus.sum), 64'd3735930558);
    ack_result();
`endif

    // 7: ACK_sum in IDLE and start in COLLECT are ignored
    en_base = en_cnt;
    bus.ACK_sum = 1'b1;
    tick();
    tick();
    tick();
    bus.ACK_sum = 1'b0;
    check_val("t7_ack_idle_state", 64'(dbg_state), 64'(S_IDLE));
    check_val("t7_ack_idle_en", 64'(en_cnt - en_base), 64'd0);
    fill_const(32'd2);
    start_burst(0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.start = (i >= 5 && i < 10);
      bus.VALID_memVal = 1'b1;
      bus.memVal = data_a[i];
      tick();
    end
    bus.start = 1'b0;
    bus.VALID_memVal = 1'b0;
    check_val("t7_state", 64'(dbg_state), 64'(S_DONE));
    check_val("t7_sum", 64'(bus.sum), 64'd128);
    check_val("t7_en_pulses", 64'(en_cnt - en_base), 64'd1);
    ack_result();
    tick();
    tick();
    check_val("t7_stay_idle", 64'(dbg_state), 64'(S_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
